cci_write_sequencer: RTL and testbench

- Downstream consumer of the IMX219 init register table.
- Walks the table entry by entry and issues one CCI (I2C) write per entry to sensor 7-bit address DEV_ADDR: START, dev-addr+W, reg addr MSB, reg addr LSB, data, STOP.
- Pulses the table's step strobe after each write and reports done/error to the top control.
- Drives open-drain SCL/SDA enables to the pad wrapper.

---
 rtl/cci_pkg.sv | 18 +
 rtl/cci_bit_timer.sv | 46 ++++
 rtl/cci_write_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_cci_write_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_pkg.sv
// rtl/cci_pkg.sv - shared types and constants for the CCI write sequencer
package cci_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, WAIT1, START, BYTE, STOP, GAP, STEP, DONE, ERR
  } cci_state_e;

  localparam logic CCI_WRITE_BIT   = 1'b0;
  localparam int   BITS_PER_BYTE   = 9;
  localparam int   BYTES_PER_WRITE = 4;
  localparam int   STEP_SETTLE     = 2;

  // Last quarter index of each bus phase; the bit timer wraps after it.
  localparam logic [1:0] Q_LAST_START = 2'd1;
  localparam logic [1:0] Q_LAST_BYTE  = 2'd3;
  localparam logic [1:0] Q_LAST_STOP  = 2'd2;

endpackage

// File: rtl/cci_bit_timer.sv
// rtl/cci_bit_timer.sv - quarter-SCL-period tick generator with wrapping quarter index
module cci_bit_timer #(
  parameter int QUARTER_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] last_q_i,
  output logic       qtick_o,
  output logic [1:0] quarter_o
);

  localparam int CW = (QUARTER_DIV > 2) ? $clog2(QUARTER_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(QUARTER_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    q_q, q_d;

  always_comb begin
    qtick_o = en_i && (cnt_q == CNT_MAX);
    cnt_d   = cnt_q;
    q_d     = q_q;
    if (!en_i) begin
      cnt_d = '0;
      q_d   = '0;
    end else if (qtick_o) begin
      cnt_d = '0;
      q_d   = (q_q == last_q_i) ? 2'd0 : q_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      q_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign quarter_o = q_q;

endmodule

// File: rtl/cci_write_sequencer.sv
// rtl/cci_write_sequencer.sv - walks the init table issuing one CCI write per entry; CCI_NACK_RETRY_EN enables NACK retries
module cci_write_sequencer
  import cci_pkg::*;
#(
  parameter int         QUARTER_DIV = 250,
  parameter logic [6:0] DEV_ADDR    = 7'h10,
  parameter int         GAP_CYCLES  = 1000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        run_init,
  output logic        read_enable,
  output logic        step_increment,
  input  logic [15:0] current_address_in,
  input  logic [7:0]  current_data_in,
  input  logic        complete_in,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  nack_count
);

  localparam int GW = ($clog2(GAP_CYCLES + 1) > 2) ? $clog2(GAP_CYCLES + 1) : 2;
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] STEP_LAST = GW'(STEP_SETTLE);
  localparam logic [3:0]    LAST_POS  = 4'(BITS_PER_BYTE - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WRITE - 1);

  cci_state_e     state_q, state_d;
  logic [31:0]    shift_q, shift_d;
  logic [3:0]     pos_q, pos_d;
  logic [1:0]     byte_q, byte_d;
  logic           nack_q, nack_d;
  logic [GW-1:0]  wait_q, wait_d;
  logic           busy_q, busy_d, run_q, run_d, done_q, done_d, err_q, err_d;
  logic [7:0]     nack_cnt_q, nack_cnt_d;

  logic           tmr_en, qtick;
  logic [1:0]     tmr_last, quarter;

`ifdef CCI_NACK_RETRY_EN
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0]  retry_q, retry_d;
`else
  localparam int unused_max_retry = MAX_RETRY;
`endif

  cci_bit_timer #(.QUARTER_DIV(QUARTER_DIV)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (tmr_en),
    .last_q_i  (tmr_last),
    .qtick_o   (qtick),
    .quarter_o (quarter)
  );

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    pos_d          = pos_q;
    byte_d         = byte_q;
    nack_d         = nack_q;
    wait_d         = '0;
    busy_d         = busy_q;
    run_d          = run_q;
    done_d         = done_q;
    err_d          = err_q;
    nack_cnt_d     = nack_cnt_q;
    read_enable    = 1'b0;
    step_increment = 1'b0;
    scl_oe         = 1'b0;
    sda_oe         = 1'b0;
    tmr_en         = 1'b0;
    tmr_last       = Q_LAST_BYTE;
`ifdef CCI_NACK_RETRY_EN
    retry_d        = retry_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        busy_d  = 1'b1;
        run_d   = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef CCI_NACK_RETRY_EN
        retry_d = '0;
`endif
        state_d = FETCH;
      end
      FETCH: begin
        read_enable = 1'b1;
        state_d     = WAIT1;
      end
      WAIT1: begin
        shift_d = {DEV_ADDR, CCI_WRITE_BIT, current_address_in, current_data_in};
        pos_d   = '0;
        byte_d  = '0;
        nack_d  = 1'b0;
        state_d = complete_in ? DONE : START;
      end
      START: begin
        tmr_en   = 1'b1;
        tmr_last = Q_LAST_START;
        sda_oe   = (quarter == 2'd1);
        if (qtick && quarter == Q_LAST_START) state_d = BYTE;
      end
      BYTE: begin
        tmr_en = 1'b1;
        scl_oe = (quarter == 2'd0) || (quarter == 2'd3);
        sda_oe = (pos_q != LAST_POS) && !shift_q[31];
        if (qtick && quarter == 2'd2 && pos_q == LAST_POS && sda_i) begin
          nack_d = 1'b1;
          if (nack_cnt_q != 8'hFF) nack_cnt_d = nack_cnt_q + 8'd1;
        end
        if (qtick && quarter == 2'd3) begin
          if (pos_q == LAST_POS) begin
            pos_d  = '0;
            byte_d = byte_q + 2'd1;
            if (nack_q || byte_q == LAST_BYTE) state_d = STOP;
          end else begin
            pos_d   = pos_q + 4'd1;
            shift_d = {shift_q[30:0], 1'b0};
          end
        end
      end
      STOP: begin
        tmr_en   = 1'b1;
        tmr_last = Q_LAST_STOP;
        scl_oe   = (quarter == 2'd0);
        sda_oe   = (quarter != 2'd2);
        if (qtick && quarter == Q_LAST_STOP) begin
`ifdef CCI_NACK_RETRY_EN
          state_d = GAP;
`else
          state_d = nack_q ? ERR : GAP;
`endif
        end
      end
      GAP: begin
        wait_d = wait_q + GW'(1);
        if (wait_q == GAP_LAST) begin
          wait_d  = '0;
          state_d = STEP;
`ifdef CCI_NACK_RETRY_EN
          if (!nack_q) begin
            retry_d = '0;
          end else if (retry_q == RW'(MAX_RETRY)) begin
            state_d = ERR;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = FETCH;
          end
`endif
        end
      end
      // Pulse first, then let the table's complete flag settle before re-reading.
      STEP: begin
        step_increment = (wait_q == '0);
        wait_d         = wait_q + GW'(1);
        if (wait_q == STEP_LAST) begin
          wait_d  = '0;
          state_d = FETCH;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        run_d   = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        run_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      pos_q      <= '0;
      byte_q     <= '0;
      nack_q     <= 1'b0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      nack_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      pos_q      <= pos_d;
      byte_q     <= byte_d;
      nack_q     <= nack_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      run_q      <= run_d;
      done_q     <= done_d;
      err_q      <= err_d;
      nack_cnt_q <= nack_cnt_d;
    end
  end

`ifdef CCI_NACK_RETRY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) retry_q <= '0;
    else        retry_q <= retry_d;
  end
`endif

  assign busy       = busy_q;
  assign run_init   = run_q;
  assign done       = done_q;
  assign error      = err_q;
  assign nack_count = nack_cnt_q;

endmodule

// File: tb/tb_cci_write_sequencer.sv
// tb/tb_cci_write_sequencer.sv - scoreboard bench: table model, I2C slave/monitor, reference transaction list
module tb_cci_write_sequencer;

  localparam int NENT = 59;
  localparam int MAXR = 3;
`ifdef CCI_NACK_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  nbytes;
    logic [31:0] word;
    logic        nack;
  } tx_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        run_init, read_enable, step_increment, scl_oe, sda_oe, sda_i;
  logic        busy, done, error;
  logic [7:0]  nack_count;
  logic [15:0] current_address_in = '0;
  logic [7:0]  current_data_in = '0;
  logic        complete_in = 1'b0;
  logic        slave_pull = 1'b0;

  int vectors = 0, miscompares = 0;
  int tx_count = 0, steps = 0, done_rises = 0, nack_mode = 0, pb = 0;
  logic [23:0] tbl [NENT];
  int tstep = 0;
  tx_t exp_q[$];

  always #5 clk = ~clk;

  assign sda_i = ~(sda_oe | slave_pull);

  cci_write_sequencer #(
    .QUARTER_DIV(2), .DEV_ADDR(7'h10), .GAP_CYCLES(4), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run_init(run_init),
    .read_enable(read_enable), .step_increment(step_increment),
    .current_address_in(current_address_in), .current_data_in(current_data_in),
    .complete_in(complete_in), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i),
    .busy(busy), .done(done), .error(error), .nack_count(nack_count)
  );

  // Register table: registered outputs, complete flag lags the step by one cycle.
  always @(posedge clk) begin
    if (!run_init) tstep <= 0;
    else if (step_increment) tstep <= tstep + 1;
    complete_in <= (tstep >= NENT);
    if (read_enable) begin
      if (tstep < NENT) {current_address_in, current_data_in} <= tbl[tstep];
      else {current_address_in, current_data_in} <= '0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_tx(input bit bits[$]);
    int k;
    logic [31:0] w;
    logic nk;
    tx_t e;
    k = bits.size() / 9;
    w = '0;
    nk = 1'b0;
    for (int i = 0; i < 9 * k; i++) begin
      if (i % 9 == 8) nk = nk | bits[i];
      else w = {w[30:0], bits[i]};
    end
    if (k < 4) w = w << (8 * (4 - k));
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL tx_unexpected: got %0d bytes %08h nack=%0b, expected none", k, w, nk);
    end else begin
      e = exp_q.pop_front();
      if (e.nbytes != 8'(k) || e.word != w || e.nack != nk) begin
        miscompares++;
        $display("FAIL tx%0d: got %0d bytes %08h nack=%0b, expected %0d bytes %08h nack=%0b",
                 tx_count - 1, k, w, nk, e.nbytes, e.word, e.nack);
      end
    end
  endtask

  // Bus monitor and ACKing slave, sampled on the falling clock edge.
  initial begin : mon
    logic scl, sda, prev_scl, prev_sda, nk;
    bit   bits[$];
    bit   in_tx;
    prev_scl = 1'b1;
    prev_sda = 1'b1;
    in_tx = 1'b0;
    forever begin
      @(negedge clk);
      scl = ~scl_oe;
      sda = sda_i;
      if (!rst_n) begin
        in_tx = 1'b0;
        bits.delete();
        pb = 0;
        slave_pull = 1'b0;
      end else if (prev_scl && scl && prev_sda && !sda) begin
        in_tx = 1'b1;
        bits.delete();
        pb = 0;
        tx_count++;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        if (in_tx) check_tx(bits);
        in_tx = 1'b0;
      end else if (!prev_scl && scl && in_tx) begin
        bits.push_back(sda);
        pb++;
      end else if (prev_scl && !scl && in_tx) begin
        if (pb == 8) begin
          nk = (nack_mode == 2) || (nack_mode == 1 && tx_count == 4 && bits.size() / 9 == 0);
          slave_pull = !nk;
        end else if (pb == 9) begin
          slave_pull = 1'b0;
          pb = 0;
        end
      end
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  initial begin : counters
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (step_increment) begin
        steps++;
        check("step_during_bus", {scl_oe, sda_oe}, 2'b00);
      end
      if (done && !done_prev) done_rises++;
      done_prev = done;
    end
  end

  // Reference model: a write is retried only while retries remain; each clean write steps the table.
  task automatic push_expected(input int mode, output int es, output int en, output bit fin);
    int att;
    bit nk;
    es = 0;
    en = 0;
    fin = 1'b1;
    for (int e = 0; e < NENT; e++) begin
      att = 0;
      while (1) begin
        nk = (mode == 2) || (mode == 1 && e == 3 && att == 0);
        if (!nk) begin
          exp_q.push_back('{nbytes: 8'd4, word: {8'h20, tbl[e]}, nack: 1'b0});
          es++;
          break;
        end
        exp_q.push_back('{nbytes: 8'd1, word: 32'h2000_0000, nack: 1'b1});
        en++;
        att++;
        if (!RETRY || att > MAXR) begin
          fin = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_idle(input int extra);
    int pulses[$];
    bit fin_ok;
    for (int k = 0; k < extra; k++) pulses.push_back($urandom_range(200, 16000));
    pulse_start();
    fin_ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      start = 1'b0;
      foreach (pulses[j]) if (pulses[j] == i) start = 1'b1;
      @(negedge clk);
      if (!busy) begin
        fin_ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("run_completes", fin_ok, 1'b1);
  endtask

  task automatic final_checks(input int es, input int en, input bit fin);
    repeat (20) @(negedge clk);
    check("steps", steps, es);
    check("nack_count", nack_count, en);
    check("done", done, fin);
    check("error", error, !fin);
    check("run_init_end", run_init, 1'b0);
    check("busy_end", busy, 1'b0);
    check("unsent_tx", exp_q.size(), 0);
    check("done_pulses", done_rises, fin);
  endtask

  task automatic prepare(input int mode, output int es, output int en, output bit fin);
    do_reset();
    tx_count = 0;
    steps = 0;
    done_rises = 0;
    nack_mode = mode;
    exp_q.delete();
    push_expected(mode, es, en, fin);
  endtask

  initial begin : stim
    int es, en;
    bit fin, hit;
    for (int i = 0; i < NENT; i++) tbl[i] = 24'($urandom);
    tbl[0]  = 24'h010000;
    tbl[3]  = 24'h012A18;
    tbl[58] = 24'h010001;

    do_reset();
    check("rst_run_init", run_init, 1'b0);
    check("rst_read_enable", read_enable, 1'b0);
    check("rst_step_increment", step_increment, 1'b0);
    check("rst_scl_oe", scl_oe, 1'b0);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_nack_count", nack_count, 8'd0);

    for (int mode = 0; mode < 3; mode++) begin
      prepare(mode, es, en, fin);
      repeat ($urandom_range(1, 30)) @(negedge clk);
      run_to_idle(0);
      final_checks(es, en, fin);
    end

    prepare(0, es, en, fin);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (tx_count == 11 && pb == 1) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_entry10_bit2", hit, 1'b1);
    repeat (7 + $urandom_range(0, 2)) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_scl_oe", scl_oe, 1'b0);
    check("midrst_sda_oe", sda_oe, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_run_init", run_init, 1'b0);
    check("tx_before_reset", exp_q.size(), NENT - 10);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tx_count = 0;
    steps = 0;
    done_rises = 0;
    push_expected(0, es, en, fin);
    run_to_idle(5);
    final_checks(es, en, fin);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
